// File: rtl/uio_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uio_arb_pkg
// Description : Shared types and constants for the uio pad-sharing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uio_arb_pkg;

  localparam int UIO_W = 8;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

  // Encodes a one-hot vector of up to eight requesters into an index.
  function automatic logic [2:0] oh8_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uio_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uio_bus_arbiter_if
// Description : Requester handshake and pad-side signals of the uio arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uio_bus_arbiter_if #(
  parameter int NUM_REQ = 4
) ();

  logic                                  ena;
  logic [NUM_REQ-1:0]                    req;
  logic [NUM_REQ-1:0]                    req_dir;
  logic [NUM_REQ-1:0]                    req_last;
  logic [uio_arb_pkg::UIO_W*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]                    gnt;
  logic [uio_arb_pkg::UIO_W-1:0]         rdata;
  logic [NUM_REQ-1:0]                    rvalid;
  logic [uio_arb_pkg::UIO_W-1:0]         uio_in;
  logic [uio_arb_pkg::UIO_W-1:0]         uio_out;
  logic [uio_arb_pkg::UIO_W-1:0]         uio_oe;

  // Requesters plus pad driver side.
  modport master (
    output ena, req, req_dir, req_last, wdata, uio_in,
    input  gnt, rdata, rvalid, uio_out, uio_oe
  );

  // Arbiter side.
  modport slave (
    input  ena, req, req_dir, req_last, wdata, uio_in,
    output gnt, rdata, rvalid, uio_out, uio_oe
  );

endinterface
`default_nettype wire

// File: rtl/uio_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; lowest index at/after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             any
);

  localparam logic [PTR_W:0] c_n = (PTR_W+1)'(N);

  logic [PTR_W:0] w_sum;

  assign any = |req;

  // Walk offsets from farthest to nearest so the nearest request overrides.
  always_comb begin
    win   = '0;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (w_sum >= c_n) w_sum = w_sum - c_n;
      if (req[w_sum[PTR_W-1:0]]) begin
        win                   = '0;
        win[w_sum[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uio_bus_arbiter
// Description : Round-robin burst scheduler sharing the 8 uio pads.
// Revision    : 1.0 - initial release
// ============================================================================
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  uio_bus_arbiter_if.slave  bus
);

  localparam int c_ptr_w  = $clog2(NUM_REQ);
  localparam int c_beat_w = $clog2(MAX_BURST + 1);

  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(MAX_BURST - 1);
  localparam logic [c_ptr_w-1:0]  c_ptr_max   = c_ptr_w'(NUM_REQ - 1);
  localparam logic [1:0]          c_turn_init = 2'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
  localparam logic                c_has_turn  = (TURNAROUND > 0);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [c_ptr_w-1:0]    r_ptr;
  logic [c_ptr_w-1:0]    w_ptr_nxt;
  logic [c_ptr_w-1:0]    r_owner;
  logic [c_ptr_w-1:0]    w_owner_nxt;
  logic                  r_cur_dir;
  logic                  w_dir_nxt;
  logic [c_beat_w-1:0]   r_beats;
  logic [c_beat_w-1:0]   w_beats_nxt;
  logic [1:0]            r_turn_cnt;
  logic [1:0]            w_turn_nxt;

  logic [UIO_W-1:0]      r_uio_out;
  logic [UIO_W-1:0]      r_uio_oe;
  logic [UIO_W-1:0]      r_rdata;
  logic [NUM_REQ-1:0]    r_rvalid;

  logic [NUM_REQ-1:0]    w_win;
  logic                  w_any;
  logic [c_ptr_w-1:0]    w_win_idx;
  logic [NUM_REQ-1:0]    w_owner_oh;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_beat;
  logic                  w_owner_req;
  logic                  w_owner_last;
  logic [UIO_W-1:0]      w_owner_wdata;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (c_ptr_w)
  ) u_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .win (w_win),
    .any (w_any)
  );

  assign w_win_idx     = c_ptr_w'(oh8_to_idx(8'(w_win)));
  assign w_owner_oh    = NUM_REQ'(1) << r_owner;
  assign w_owner_req   = bus.req[r_owner];
  assign w_owner_last  = bus.req_last[r_owner];
  assign w_owner_wdata = bus.wdata[{r_owner, 3'b000} +: UIO_W];

  // Next-state, burst bookkeeping and grant.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_dir_nxt   = r_cur_dir;
    w_beats_nxt = r_beats;
    w_turn_nxt  = r_turn_cnt;
    w_gnt       = '0;
    w_beat      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.ena && w_any) begin
          w_owner_nxt = w_win_idx;
          w_dir_nxt   = bus.req_dir[w_win_idx];
          w_beats_nxt = '0;
          w_turn_nxt  = c_turn_init;
          if (c_has_turn && (bus.req_dir[w_win_idx] != r_cur_dir)) begin
            w_state_nxt = ST_TURN;
          end else begin
            w_state_nxt = ST_XFER;
          end
        end
      end

      ST_TURN: begin
        if (r_turn_cnt == 2'd0) begin
          w_state_nxt = ST_XFER;
        end else begin
          w_turn_nxt = r_turn_cnt - 2'd1;
        end
      end

      ST_XFER: begin
        if (w_owner_req) begin
          w_beat      = 1'b1;
          w_gnt       = w_owner_oh;
          w_beats_nxt = r_beats + c_beat_w'(1);
        end
        // A dropped request ends the burst without a beat in that cycle.
        if (!w_owner_req || w_owner_last || (r_beats == c_last_beat)) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_owner == c_ptr_max) ? '0 : r_owner + c_ptr_w'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (rst) begin
      w_gnt  = '0;
      w_beat = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cur_dir  <= DIR_IN;
      r_beats    <= '0;
      r_turn_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_cur_dir  <= w_dir_nxt;
      r_beats    <= w_beats_nxt;
      r_turn_cnt <= w_turn_nxt;
    end
  end

  // Pad and read-data registers; oe is only high the cycle after an out beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_uio_out <= '0;
      r_uio_oe  <= '0;
      r_rdata   <= '0;
      r_rvalid  <= '0;
    end else begin
      r_uio_oe <= (w_beat && (r_cur_dir == DIR_OUT)) ? {UIO_W{1'b1}} : '0;
      r_rvalid <= (w_beat && (r_cur_dir == DIR_IN)) ? w_owner_oh : '0;
      if (w_beat && (r_cur_dir == DIR_OUT)) r_uio_out <= w_owner_wdata;
      if (w_beat && (r_cur_dir == DIR_IN))  r_rdata   <= bus.uio_in;
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.uio_out = r_uio_out;
  assign bus.uio_oe  = r_uio_oe;
  assign bus.rdata   = r_rdata;
  assign bus.rvalid  = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uio_bus_arbiter
// Description : Directed scoreboard bench for uio_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uio_bus_arbiter;
  import uio_arb_pkg::*;

  localparam int NR = 4;

  typedef struct {
    int          ch;
    int          cyc;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  uio_bus_arbiter_if #(.NUM_REQ(NR)) bus ();

  uio_bus_arbiter #(
    .NUM_REQ    (NR),
    .MAX_BURST  (4),
    .TURNAROUND (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Channel 0 = gnt, 1 = {rvalid, rdata}, 2 = {uio_oe, uio_out}.
  task automatic push(input int ch, input int c, input logic [15:0] v);
    exp_t e;
    e.ch  = ch;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] fval(input int c);
    return 8'(c * 13 + 7);
  endfunction

  // Monitor: matches every visible output against the scoreboard by cycle.
  always @(negedge clk) begin : mon
    logic [15:0] act;
    bit          hit;
    for (int ch = 0; ch < 3; ch++) begin
      case (ch)
        0:       act = {12'h000, bus.gnt};
        1:       act = (bus.rvalid != '0) ? {4'h0, bus.rvalid, bus.rdata} : 16'h0000;
        default: act = (bus.uio_oe != '0) ? {bus.uio_oe, bus.uio_out} : 16'h0000;
      endcase
      hit = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].ch == ch && sb[i].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL missed ch%0d at cyc %0d: got none want %h", ch, sb[i].cyc, sb[i].val);
          sb.delete(i);
        end else if (sb[i].ch == ch && sb[i].cyc == cyc) begin
          total++;
          hit = 1'b1;
          if (act !== sb[i].val) begin
            bad++;
            $display("FAIL ch%0d at cyc %0d: got %h want %h", ch, cyc, act, sb[i].val);
          end
          sb.delete(i);
        end
      end
      if (!hit && act != 16'h0000) begin
        total++;
        bad++;
        $display("FAIL unexpected ch%0d at cyc %0d: got %h want 0000", ch, cyc, act);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, j, f, d, e, s;
    rst          = 1'b1;
    bus.ena      = 1'b1;
    bus.req      = '0;
    bus.req_dir  = '0;
    bus.req_last = '0;
    bus.wdata    = '0;
    bus.uio_in   = '0;
    tick(3);
    chk("rst_gnt",     16'(bus.gnt),     16'h0);
    chk("rst_rvalid",  16'(bus.rvalid),  16'h0);
    chk("rst_rdata",   16'(bus.rdata),   16'h0);
    chk("rst_uio_out", 16'(bus.uio_out), 16'h0);
    chk("rst_uio_oe",  16'(bus.uio_oe),  16'h0);
    rst = 1'b0;
    tick(2);

    // Single out burst from req0; reset direction is in, so one TURN cycle.
    k = cyc;
    bus.req = 4'b0001; bus.req_dir = 4'b0001; bus.req_last = 4'b0000;
    bus.wdata[7:0] = 8'hA1;
    push(0, k + 2, 16'h0001);
    push(0, k + 3, 16'h0001);
    push(2, k + 3, 16'hFFA1);
    push(2, k + 4, 16'hFFA2);
    tick(3);
    bus.wdata[7:0] = 8'hA2; bus.req_last = 4'b0001;
    tick(1);
    bus.req = 4'b0000; bus.req_last = 4'b0000;
    tick(2);

    // Out beat from req1 (no turn), then in burst from req2 (one turn).
    j = cyc;
    bus.req = 4'b0010; bus.req_dir = 4'b0010; bus.req_last = 4'b0010;
    bus.wdata[15:8] = 8'hB7;
    push(0, j + 1, 16'h0002);
    push(2, j + 2, 16'hFFB7);
    tick(2);
    bus.req = 4'b0100; bus.req_dir = 4'b0000; bus.req_last = 4'b0100;
    bus.uio_in = 8'h5C;
    push(0, j + 4, 16'h0004);
    push(1, j + 5, 16'h045C);
    tick(3);
    bus.req = 4'b0000; bus.req_last = 4'b0000;
    tick(2);

    // Fairness from a fresh reset: all four in, MAX_BURST beats each.
    rst = 1'b1;
    tick(2);
    chk("rst2_rdata", 16'(bus.rdata), 16'h0);
    rst = 1'b0;
    f = cyc;
    bus.req = 4'b1111; bus.req_dir = 4'b0000; bus.req_last = 4'b0000;
    bus.uio_in = fval(f);
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 4; i++) begin
        push(0, f + 1 + 5 * b + i, 16'(1 << (b % 4)));
        push(1, f + 2 + 5 * b + i, {4'h0, 4'(1 << (b % 4)), fval(f + 1 + 5 * b + i)});
      end
    end
    for (int c = f + 1; c <= f + 25; c++) begin
      tick(1);
      if (cyc == f + 25) bus.req = 4'b0000;
      else               bus.uio_in = fval(cyc);
    end
    tick(2);

    // Early drop: req1 leaves after two beats, req2 is served next.
    d = cyc;
    bus.req = 4'b0110; bus.req_dir = 4'b0000; bus.req_last = 4'b0100;
    bus.uio_in = 8'hC3;
    push(0, d + 1, 16'h0002);
    push(0, d + 2, 16'h0002);
    push(1, d + 2, 16'h02C3);
    push(1, d + 3, 16'h02C3);
    push(0, d + 5, 16'h0004);
    push(1, d + 6, 16'h04C3);
    tick(3);
    bus.req = 4'b0100;
    tick(3);

    // ena low blocks new bursts; raising it grants one cycle later.
    bus.req = 4'b1000; bus.req_last = 4'b1000; bus.ena = 1'b0;
    bus.uio_in = 8'h6E;
    e = cyc;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("ena_low_gnt", 16'(bus.gnt), 16'h0);
    end
    bus.ena = 1'b1;
    push(0, e + 11, 16'h0008);
    push(1, e + 12, 16'h086E);
    tick(2);
    bus.req = 4'b0000; bus.req_last = 4'b0000;
    tick(1);

    // Move ptr off zero, start an out burst, then reset in the middle.
    s = cyc;
    bus.req = 4'b0001; bus.req_dir = 4'b0000; bus.req_last = 4'b0001;
    bus.uio_in = 8'h11;
    push(0, s + 1, 16'h0001);
    push(1, s + 2, 16'h0111);
    tick(2);
    bus.req = 4'b0100; bus.req_dir = 4'b0100; bus.req_last = 4'b0000;
    bus.wdata[23:16] = 8'hE5;
    push(0, s + 4, 16'h0004);
    push(2, s + 5, 16'hFFE5);
    tick(3);
    rst = 1'b1;
    #1;
    chk("rst_cycle_gnt", 16'(bus.gnt), 16'h0);
    tick(1);
    chk("midrst_gnt",     16'(bus.gnt),     16'h0);
    chk("midrst_rvalid",  16'(bus.rvalid),  16'h0);
    chk("midrst_rdata",   16'(bus.rdata),   16'h0);
    chk("midrst_uio_out", 16'(bus.uio_out), 16'h0);
    chk("midrst_uio_oe",  16'(bus.uio_oe),  16'h0);
    rst = 1'b0;
    // ptr back at 0 and direction back to in: req0 wins with no turn.
    bus.req = 4'b0011; bus.req_dir = 4'b0000; bus.req_last = 4'b0011;
    push(0, s + 7,  16'h0001);
    push(1, s + 8,  16'h0111);
    push(0, s + 9,  16'h0002);
    push(1, s + 10, 16'h0211);
    tick(2);
    bus.req = 4'b0010;
    tick(2);
    bus.req = 4'b0000; bus.req_last = 4'b0000;
    tick(4);

    chk("sb_drained", 16'(sb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
